rx_packet_buffer: RTL and testbench

Packet-level receive FIFO between the `usb_rx` receiver and the AHB-Lite slave interface of the bulk endpoint. It holds up to 64 bytes. Bytes from `usb_rx` are written speculatively. They become readable only when the DATA packet completes with a good CRC, and they are rolled back on error or overrun. The AHB side pops committed bytes one at a time and sees the current occupancy.

---
 rtl/rx_packet_buffer.sv | 170 +++++++++++++++++
 tb/tb_rx_packet_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_buffer.sv
// Packet-level receive FIFO (64 bytes) between usb_rx and the AHB-Lite bulk endpoint.
// Optional discarded-packet counter enabled by defining RX_BUF_ERR_COUNT_EN.
module rx_packet_buffer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic [7:0] rx_packet_data,
  input  logic       store_rx_packet_data,
  input  logic       get_rx_data,
  input  logic       flush,
  output logic [7:0] rx_data,
  output logic [6:0] buffer_occupancy,
  output logic       rx_data_ready,
  output logic       rx_overrun,
  output logic       rx_error,
  output logic [7:0] error_count
);

  localparam logic [2:0] PktNone     = 3'd0;
  localparam logic [2:0] PktDataRx   = 3'd3;
  localparam logic [2:0] PktDataDone = 3'd4;
  localparam logic [2:0] PktError    = 3'd7;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0] state_q, state_d;
  logic [6:0] wr_ptr_q, wr_ptr_d;
  logic [6:0] cm_ptr_q, cm_ptr_d;
  logic [6:0] rd_ptr_q, rd_ptr_d;
  logic [6:0] wr_next;
  logic [7:0] rx_data_q;
  logic       overrun_q, overrun_d;
  logic       error_q, error_d;
  logic [7:0] mem [64];

  logic [6:0] occupancy;
  logic       full;
  logic       pop_en;
  logic       write_en;
  logic       discard;
  logic       pkt_end;

  // Full counts speculative bytes too: wr_ptr may run ahead of cm_ptr.
  assign occupancy = cm_ptr_q - rd_ptr_q;
  assign full      = (wr_ptr_q - rd_ptr_q) == 7'd64;
  assign pop_en    = get_rx_data && (occupancy != 7'd0) && !flush;
  assign pkt_end   = (rx_packet == PktError) || (rx_packet == PktNone);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    error_d   = error_q;
    write_en  = 1'b0;
    discard   = 1'b0;
    wr_next   = wr_ptr_q + {6'd0, store_rx_packet_data};

    if (flush) begin
      state_d   = StIdle;
      wr_ptr_d  = 7'd0;
      cm_ptr_d  = 7'd0;
      rd_ptr_d  = 7'd0;
      overrun_d = 1'b0;
      error_d   = 1'b0;
    end else begin
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + 7'd1;
      end

      case (state_q)
        StIdle: begin
          if (rx_packet == PktDataRx) begin
            state_d = StRecv;
          end
        end
        StRecv: begin
          if (store_rx_packet_data && full) begin
            overrun_d = 1'b1;
            state_d   = StDrop;
          end else begin
            write_en = store_rx_packet_data;
            wr_ptr_d = wr_next;
            // A byte strobed alongside DATA_DONE is part of the commit.
            if (rx_packet == PktDataDone) begin
              cm_ptr_d = wr_next;
              state_d  = StIdle;
            end else if (pkt_end) begin
              wr_ptr_d = cm_ptr_q;
              discard  = 1'b1;
              state_d  = StIdle;
            end
          end
        end
        StDrop: begin
          if (pkt_end || (rx_packet == PktDataDone)) begin
            wr_ptr_d = cm_ptr_q;
            discard  = 1'b1;
            state_d  = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      error_d = error_q | discard;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= 7'd0;
      cm_ptr_q  <= 7'd0;
      rd_ptr_q  <= 7'd0;
      overrun_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
      error_q   <= error_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_q <= 8'h00;
    end else if (pop_en) begin
      rx_data_q <= mem[rd_ptr_q[5:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr_q[5:0]] <= rx_packet_data;
    end
  end

`ifdef RX_BUF_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_cnt_q <= 8'h00;
    end else if (flush) begin
      err_cnt_q <= 8'h00;
    end else if (discard && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign error_count = err_cnt_q;
`else
  assign error_count = 8'h00;
`endif

  assign rx_data          = rx_data_q;
  assign buffer_occupancy = occupancy;
  assign rx_data_ready    = occupancy != 7'd0;
  assign rx_overrun       = overrun_q;
  assign rx_error         = error_q;

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Self-checking bench for rx_packet_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_rx_packet_buffer;

  logic       clk;
  logic       n_rst;
  logic [2:0] rx_packet;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic       get_rx_data;
  logic       flush;
  logic [7:0] rx_data;
  logic [6:0] buffer_occupancy;
  logic       rx_data_ready;
  logic       rx_overrun;
  logic       rx_error;
  logic [7:0] error_count;

  rx_packet_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .rx_packet            (rx_packet),
    .rx_packet_data       (rx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .get_rx_data          (get_rx_data),
    .flush                (flush),
    .rx_data              (rx_data),
    .buffer_occupancy     (buffer_occupancy),
    .rx_data_ready        (rx_data_ready),
    .rx_overrun           (rx_overrun),
    .rx_error             (rx_error),
    .error_count          (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: committed bytes, bytes of the packet in flight, receive mode.
  logic [7:0] cq[$];
  logic [7:0] pq[$];
  bit         in_pkt;
  bit         dropping;
  bit         m_ovr;
  bit         m_err;
  int         m_cnt;
  logic [7:0] m_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    pq.delete();
    in_pkt   = 0;
    dropping = 0;
    m_ovr    = 0;
    m_err    = 0;
    m_cnt    = 0;
    m_data   = 8'h00;
  endtask

  task automatic model_discard();
    pq.delete();
    m_err = 1;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_step(input logic [2:0] pkt, input logic st, input logic [7:0] d,
                            input logic get, input logic fl);
    bit full;
    if (fl) begin
      cq.delete();
      pq.delete();
      in_pkt   = 0;
      dropping = 0;
      m_ovr    = 0;
      m_err    = 0;
      m_cnt    = 0;
    end else begin
      full = (cq.size() + pq.size()) == 64;
      if (get && cq.size() != 0) m_data = cq.pop_front();
      if (dropping) begin
        if (pkt == 3'd4 || pkt == 3'd7 || pkt == 3'd0) begin
          model_discard();
          dropping = 0;
        end
      end else if (in_pkt) begin
        if (st && full) begin
          m_ovr    = 1;
          in_pkt   = 0;
          dropping = 1;
        end else begin
          if (st) pq.push_back(d);
          if (pkt == 3'd4) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
            in_pkt = 0;
          end else if (pkt == 3'd7 || pkt == 3'd0) begin
            model_discard();
            in_pkt = 0;
          end
        end
      end else if (pkt == 3'd3) begin
        in_pkt = 1;
      end
    end
  endtask

  task automatic compare_all();
    int exp_cnt;
`ifdef RX_BUF_ERR_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check_val("occupancy", 32'(buffer_occupancy), 32'(cq.size()));
    check_val("ready", 32'(rx_data_ready), 32'(cq.size() != 0));
    check_val("rx_data", 32'(rx_data), 32'(m_data));
    check_val("overrun", 32'(rx_overrun), 32'(m_ovr));
    check_val("error", 32'(rx_error), 32'(m_err));
    check_val("err_count", 32'(error_count), 32'(exp_cnt));
  endtask

  task automatic step(input logic [2:0] pkt, input logic st, input logic [7:0] d,
                      input logic get, input logic fl);
    rx_packet            = pkt;
    store_rx_packet_data = st;
    rx_packet_data       = d;
    get_rx_data          = get;
    flush                = fl;
    @(posedge clk);
    model_step(pkt, st, d, get, fl);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic packet(input int n, input logic [7:0] base, input logic [2:0] fin);
    step(3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(3'd3, 1'b1, base + 8'(i), 1'b0, 1'b0);
    step(fin, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    step(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val(tag, 32'(rx_data), 32'(exp));
  endtask

  initial begin
    n_rst                = 1'b0;
    rx_packet            = 3'd0;
    rx_packet_data       = 8'h00;
    store_rx_packet_data = 1'b0;
    get_rx_data          = 1'b0;
    flush                = 1'b0;
    model_reset();
    #12;
    compare_all();
    n_rst = 1'b1;
    idle(2);

    // Basic good packet, then four pops
    packet(4, 8'hA1, 3'd4);
    check_val("s1_occ", 32'(buffer_occupancy), 32'd4);
    for (int i = 0; i < 4; i++) pop_expect("s1_pop", 8'hA1 + 8'(i));
    check_val("s1_occ_end", 32'(buffer_occupancy), 32'd0);

    // Errored packet is discarded, the next good one is intact
    packet(3, 8'h50, 3'd7);
    check_val("s2_err", 32'(rx_error), 32'd1);
    packet(2, 8'hB1, 3'd4);
    pop_expect("s2_pop", 8'hB1);
    pop_expect("s2_pop", 8'hB2);
    pop_expect("s2_empty_pop", 8'hB2);

    // 64 committed, next byte overruns
    packet(64, 8'h00, 3'd4);
    check_val("s3_full", 32'(buffer_occupancy), 32'd64);
    step(3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    step(3'd3, 1'b1, 8'hEE, 1'b0, 1'b0);
    check_val("s3_ovr", 32'(rx_overrun), 32'd1);
    step(3'd3, 1'b1, 8'hEF, 1'b0, 1'b0);
    step(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    check_val("s3_occ", 32'(buffer_occupancy), 32'd64);
    check_val("s3_err", 32'(rx_error), 32'd1);

    // Wrap-around from a clean buffer
    step(3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    packet(60, 8'h80, 3'd4);
    for (int i = 0; i < 60; i++) step(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    packet(10, 8'h10, 3'd4);
    for (int i = 0; i < 10; i++) pop_expect("wrap_pop", 8'h10 + 8'(i));

    // Pop on empty, then pop concurrent with a commit whose last byte rides with DATA_DONE
    pop_expect("empty_pop", 8'h19);
    packet(2, 8'hC0, 3'd4);
    step(3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(3'd3, 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    step(3'd4, 1'b1, 8'hD4, 1'b1, 1'b0);
    check_val("pop_commit_occ", 32'(buffer_occupancy), 32'd6);
    check_val("pop_commit_data", 32'(rx_data), 32'hC0);

    // Flush mid-packet with three committed bytes
    for (int i = 0; i < 3; i++) step(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    step(3'd3, 1'b1, 8'h77, 1'b0, 1'b0);
    step(3'd3, 1'b1, 8'h78, 1'b0, 1'b1);
    check_val("flush_occ", 32'(buffer_occupancy), 32'd0);
    check_val("flush_err", 32'(rx_error), 32'd0);
    for (int i = 0; i < 3; i++) step(3'd4, 1'b1, 8'h99, 1'b0, 1'b0);
    check_val("flush_ignored", 32'(buffer_occupancy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [2:0] pkt;
      r = $urandom_range(0, 99);
      if (r < 70)      pkt = 3'd3;
      else if (r < 80) pkt = 3'd4;
      else if (r < 84) pkt = 3'd7;
      else if (r < 88) pkt = 3'd0;
      else             pkt = 3'($urandom_range(1, 6));
      step(pkt, 1'($urandom_range(0, 99) < 60), 8'($urandom),
           1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 199) == 0));
    end

    // Asynchronous reset mid-packet
    packet(5, 8'h30, 3'd4);
    step(3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    step(3'd3, 1'b1, 8'h41, 1'b0, 1'b0);
    n_rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("areset_occ", 32'(buffer_occupancy), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
